// File: rtl/alu_seq_pkg.sv
// Shared definitions for the nibble-serial ALU sequencer: slice function
// encodings, the sequencer state type and the slice width.
package alu_seq_pkg;

    // Width of the shared ALU slice; one nibble is processed per cycle.
    localparam int NIB_W = 4;

    // Arithmetic-mode function select (m = 0).
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_DEC  = 2'b11;

    // Logic-mode function select (m = 1).
    localparam logic [1:0] OP_XOR  = 2'b00;
    localparam logic [1:0] OP_NOTA = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_OR   = 2'b11;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu_seq_ctrl_simple_alu.sv
// simpleALU: the existing combinational 4-bit ALU slice.
// Arithmetic functions report co inverted (borrow polarity) when s[1]=1;
// logic functions drive co=0.
module simpleALU
    import alu_seq_pkg::*;
(
    input  logic [1:0]       s,
    input  logic             m,
    input  logic             ci,
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    output logic [NIB_W-1:0] f,
    output logic             co
);

    logic [NIB_W:0] sum;

    // Slice function: 5-bit arithmetic sum or bitwise logic result.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        sum = '0;
        f   = '0;
        co  = 1'b0;
        if (m) begin
            unique case (s)
                OP_XOR:  f = a ^ b;
                OP_NOTA: f = ~a;
                OP_AND:  f = a & b;
                default: f = a | b;
            endcase
        end else begin
            unique case (s)
                OP_ADD:  sum = {1'b0, a} + {1'b0, b}       + {{NIB_W{1'b0}}, ci};
                OP_INC:  sum = {1'b0, a} + (NIB_W+1)'(1)   + {{NIB_W{1'b0}}, ci};
                OP_SUB:  sum = {1'b0, a} + {1'b0, ~b}      + {{NIB_W{1'b0}}, ci};
                default: sum = {1'b0, a} + {1'b0, {NIB_W{1'b1}}} + {{NIB_W{1'b0}}, ci};
            endcase
            f  = sum[NIB_W-1:0];
            co = s[1] ? ~sum[NIB_W] : sum[NIB_W];
        end
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: runs a WIDTH-bit ALU operation through one shared 4-bit
// slice, LSB nibble first, chaining the carry between passes.
// Optional build macro ALU_SEQ_OVF_EN adds a registered signed-overflow flag.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    // Must be a multiple of 4 and at least 8.
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             m,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero
`ifdef ALU_SEQ_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIB   = WIDTH / NIB_W;
    localparam int IDX_W = $clog2(NIB);

    state_t             state;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [1:0]         op_reg;
    logic               m_reg;
    logic               cin_reg;
    logic               carry;
    logic [IDX_W-1:0]   idx;

    logic [1:0]         s_drv;
    logic               ci_drv;
    logic [NIB_W-1:0]   a_nib;
    logic [NIB_W-1:0]   b_nib;
    logic [NIB_W-1:0]   f_nib;
    logic               co_nib;
    logic               last_nib;
    logic [WIDTH-1:0]   next_result;

    assign last_nib = (idx == IDX_W'(NIB - 1));

    // Slice drive for the current nibble; INC adds its +1 on nibble 0 only.
    always_comb begin
        s_drv  = op_reg;
        a_nib  = a_reg[idx*NIB_W +: NIB_W];
        b_nib  = b_reg[idx*NIB_W +: NIB_W];
        ci_drv = (idx == '0) ? cin_reg : carry;
        if (!m_reg && (op_reg == OP_INC) && (idx != '0)) begin
            s_drv = OP_ADD;
            b_nib = '0;
        end
    end

    simpleALU u_slice (
        .s  (s_drv),
        .m  (m_reg),
        .ci (ci_drv),
        .a  (a_nib),
        .b  (b_nib),
        .f  (f_nib),
        .co (co_nib)
    );

    // Result word as it will look after the current nibble is stored.
    always_comb begin
        next_result = result;
        next_result[idx*NIB_W +: NIB_W] = f_nib;
    end

`ifdef ALU_SEQ_OVF_EN
    logic [WIDTH-1:0] b_eff;
    logic             ovf_next;

    // Effective second addend, so overflow is judged on the real addition.
    always_comb begin
        unique case (op_reg)
            OP_ADD:  b_eff = b_reg;
            OP_SUB:  b_eff = ~b_reg;
            OP_INC:  b_eff = '0;
            default: b_eff = '1;
        endcase
        ovf_next = !m_reg
                && (a_reg[WIDTH-1] == b_eff[WIDTH-1])
                && (next_result[WIDTH-1] != a_reg[WIDTH-1]);
    end
`endif

    // Sequencer FSM with registered handshake, result and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: operand and control registers are reset too, so an aborted operation leaves nothing stale behind.
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            cout    <= 1'b0;
            zero    <= 1'b0;
            a_reg   <= '0;
            b_reg   <= '0;
            op_reg  <= '0;
            m_reg   <= 1'b0;
            cin_reg <= 1'b0;
            carry   <= 1'b0;
            idx     <= '0;
`ifdef ALU_SEQ_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        a_reg   <= a;
                        b_reg   <= b;
                        op_reg  <= op;
                        m_reg   <= m;
                        cin_reg <= cin;
                        carry   <= 1'b0;
                        idx     <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end else begin
                        state   <= IDLE;
                    end
                end
                RUN: begin
                    result <= next_result;
                    // Slice reports an inverted carry for the subtract-like ops.
                    carry  <= op_reg[1] ? ~co_nib : co_nib;
                    idx    <= idx + 1'b1;
                    if (last_nib) begin
                        idx   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        cout  <= co_nib;
                        zero  <= (next_result == '0);
`ifdef ALU_SEQ_OVF_EN
                        ovf   <= ovf_next;
`endif
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Testbench for alu_seq_ctrl: a table of hand-computed vectors plus
// directed handshake and reset sequences. Overflow checks are included
// when ALU_SEQ_OVF_EN is defined.
module tb_alu_seq_ctrl;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic         m;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         zero;
`ifdef ALU_SEQ_OVF_EN
    logic         ovf;
`endif

    int errors = 0;
    int checks = 0;

    alu_seq_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .m      (m),
        .cin    (cin),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .zero   (zero)
`ifdef ALU_SEQ_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [1:0]   op;
        logic         m;
        logic         cin;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         cout;
        logic         zero;
        logic         ovf;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Walk negedges until done or the budget runs out; report cycles and busy count.
    task automatic wait_done(output int n, output int busy_cnt);
        n = 0;
        busy_cnt = 0;
        while (!done && n < 20) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic launch(input logic [1:0] o, input logic mm, input logic c,
                          input logic [W-1:0] aa, input logic [W-1:0] bb);
        @(negedge clk);
        op = o; m = mm; cin = c; a = aa; b = bb;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        int bc;
        launch(v.op, v.m, v.cin, v.a, v.b);
        // Scramble inputs to show operands were latched at the start edge.
        a = ~v.a; b = ~v.b; op = ~v.op; m = ~v.m; cin = ~v.cin;
        wait_done(n, bc);
        check({v.name, "_latency"}, n, 4);
        check({v.name, "_busy_cycles"}, bc, 4);
        check({v.name, "_result"}, result, v.res);
        check({v.name, "_cout"}, cout, v.cout);
        check({v.name, "_zero"}, zero, v.zero);
`ifdef ALU_SEQ_OVF_EN
        check({v.name, "_ovf"}, ovf, v.ovf);
`endif
        @(negedge clk);
        check({v.name, "_done_pulse"}, {busy, done}, 2'b00);
    endtask

    initial begin
        int n;
        int bc;
        int done_seen;

        //         name          op     m     cin   a        b        res      cout  zero  ovf
        vecs[0]  = '{"add",      2'b00, 1'b0, 1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{"add_wrap", 2'b00, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{"add_cin",  2'b00, 1'b0, 1'b1, 16'h0001, 16'h0001, 16'h0003, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{"sub_brw",  2'b10, 1'b0, 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{"sub_ok",   2'b10, 1'b0, 1'b1, 16'h0007, 16'h0005, 16'h0002, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{"dec_zero", 2'b11, 1'b0, 1'b0, 16'h0000, 16'h5A5A, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{"dec",      2'b11, 1'b0, 1'b0, 16'h1000, 16'h0000, 16'h0FFF, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{"inc",      2'b01, 1'b0, 1'b0, 16'h0FFF, 16'h1234, 16'h1000, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{"inc_cin",  2'b01, 1'b0, 1'b1, 16'h00FE, 16'h0000, 16'h0100, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{"and",      2'b10, 1'b1, 1'b0, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{"xor_zero", 2'b00, 1'b1, 1'b0, 16'hAAAA, 16'hAAAA, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{"nota",     2'b01, 1'b1, 1'b1, 16'h1234, 16'hFFFF, 16'hEDCB, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{"or",       2'b11, 1'b1, 1'b1, 16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{"ovf_add",  2'b00, 1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{"ovf_sub",  2'b10, 1'b0, 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{"ovf_xor",  2'b00, 1'b1, 1'b0, 16'h7FFF, 16'h8001, 16'hFFFE, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0; start = 1'b0; op = '0; m = 1'b0; cin = 1'b0; a = '0; b = '0;
        #12;
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_result", result, 16'h0000);
        check("reset_cout", cout, 1'b0);
        check("reset_zero", zero, 1'b0);
`ifdef ALU_SEQ_OVF_EN
        check("reset_ovf", ovf, 1'b0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) run_vec(vecs[i]);

        // Back-to-back: start held through DONE launches the next op without an idle cycle.
        launch(2'b00, 1'b0, 1'b0, 16'h0100, 16'h0020);
        start = 1'b1;
        op = 2'b10; m = 1'b0; cin = 1'b1; a = 16'h0050; b = 16'h0010;
        wait_done(n, bc);
        check("b2b_first_latency", n, 4);
        check("b2b_first_result", result, 16'h0120);
        @(negedge clk);
        check("b2b_no_idle", {busy, done}, 2'b10);
        start = 1'b0;
        wait_done(n, bc);
        check("b2b_second_latency", n, 4);
        check("b2b_second_result", result, 16'h0040);

        // start pulsed during RUN is ignored.
        launch(2'b00, 1'b0, 1'b0, 16'h1111, 16'h2222);
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n, bc);
        check("ign_latency", n, 2);
        check("ign_result", result, 16'h3333);
        @(negedge clk);
        @(negedge clk);
        check("ign_no_second_op", {busy, done}, 2'b00);

        // Reset in the second RUN cycle aborts at once with no later done pulse.
        launch(2'b00, 1'b0, 1'b0, 16'h0F0F, 16'h0101);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_result", result, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        check("abort_no_done", done_seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
